// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the logic-cell configuration loader.
// The frame is SYNC, then {LUT_LO, LUT_HI, CTRL} per cell, then an XOR checksum.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LUT_LO,
    LUT_HI,
    CTRL,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } cfg_state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         CTRL_SYNC_BIT  = 0;
  localparam int         CTRL_CARRY_BIT = 1;
  localparam logic [7:0] CTRL_RSVD_MASK = 8'hFC;

  function automatic logic ctrl_is_legal(input logic [7:0] ctrl);
    return (ctrl & CTRL_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/fpga_cfg_checksum.sv
// Running XOR of the payload bytes of one frame.
// Clear wins over enable so the SYNC byte can restart a frame in a single cycle.
module fpga_cfg_checksum (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration frames into an array of logic cells: one LUT write pulse
// per cell in index order, per-cell mux controls held, checksum verified at the end.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int N_CELLS = 4,
  parameter int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [15:0]        config_lut_o,
  output logic [N_CELLS-1:0] config_lut_we_o,
  output logic [N_CELLS-1:0] mux_sync_o,
  output logic [N_CELLS-1:0] mux_carry_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  cfg_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         lut_lo_q;
  logic [7:0]         lut_hi_q;
  logic [15:0]        config_lut_q;
  logic [N_CELLS-1:0] we_q;
  logic [N_CELLS-1:0] sync_q;
  logic [N_CELLS-1:0] carry_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  logic       accept;
  logic       chk_clr;
  logic       chk_en;
  logic [7:0] chk_sum;

  assign accept  = in_valid_i & ready_q;
  assign chk_clr = accept && (state_q == IDLE) && (in_data_i == SYNC_BYTE);
  assign chk_en  = accept && ((state_q == LUT_LO) || (state_q == LUT_HI) || (state_q == CTRL));

  fpga_cfg_checksum u_checksum (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (chk_clr),
    .en_i     (chk_en),
    .data_i   (in_data_i),
    .sum_o    (chk_sum)
  );

  // Every output is a register; ready drops only for the single WRITE cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lut_lo_q     <= 8'h00;
      lut_hi_q     <= 8'h00;
      config_lut_q <= 16'h0000;
      we_q         <= '0;
      sync_q       <= '0;
      carry_q      <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept && in_data_i == SYNC_BYTE) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LUT_LO;
          end
        end
        LUT_LO: begin
          if (accept) begin
            lut_lo_q <= in_data_i;
            state_q  <= LUT_HI;
          end
        end
        LUT_HI: begin
          if (accept) begin
            lut_hi_q <= in_data_i;
            state_q  <= CTRL;
          end
        end
        CTRL: begin
          if (accept) begin
            if (!ctrl_is_legal(in_data_i)) begin
              error_q <= 1'b1;
              state_q <= ERROR;
            end else begin
              config_lut_q   <= {lut_hi_q, lut_lo_q};
              we_q           <= N_CELLS'(1) << idx_q;
              sync_q[idx_q]  <= in_data_i[CTRL_SYNC_BIT];
              carry_q[idx_q] <= in_data_i[CTRL_CARRY_BIT];
              ready_q        <= 1'b0;
              state_q        <= WRITE;
            end
          end
        end
        WRITE: begin
          ready_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= CHECK;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= LUT_LO;
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data_i == chk_sum) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q <= 1'b1;
              state_q <= ERROR;
            end
          end
        end
        DONE, ERROR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o      = ready_q;
  assign config_lut_o    = config_lut_q;
  assign config_lut_we_o = we_q;
  assign mux_sync_o      = sync_q;
  assign mux_carry_o     = carry_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Configuration writer for an array of N_CELLS logic cells.
- Consumes a byte stream over a valid/ready handshake and drives each cell's 16-bit LUT config bus with a one-hot write enable.
- Holds each cell's static mux controls (sync/async, carry-in select).
- Sits between the external config port and the logic-cell array; one frame configures every cell, in index order.

Parameters:
- N_CELLS, 4, number of logic cells configured per frame; minimum 1.
- IDX_W, max(1, $clog2(N_CELLS)), width of the internal cell index counter.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous reset, active low
- in_data_i  in  8  stream byte
- in_valid_i  in  1  byte valid
- in_ready_o  out  1  loader accepts byte; transfer occurs when valid&ready at a rising edge
- config_lut_o  out  16  shared LUT config bus to all cells
- config_lut_we_o  out  N_CELLS  one-hot write-enable pulse; bit k targets cell k
- mux_sync_o  out  N_CELLS  per-cell sync/async select, held
- mux_carry_o  out  N_CELLS  per-cell carry-mux select, held
- busy_o  out  1  frame in progress
- done_o  out  1  last frame loaded with a good checksum
- error_o  out  1  last frame aborted

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_ni.
- Reset values: all outputs 0, except in_ready_o = 1. FSM goes to IDLE; index and checksum clear.
- Frame format:
  - SYNC byte 0xA5.
  - Then, per cell k = 0..N_CELLS-1: LUT_LO, LUT_HI, CTRL.
    - CTRL bit0 = mux_sync, bit1 = mux_carry, bits[7:2] reserved and must be 0.
  - Then CHK byte = XOR of all payload bytes (excludes SYNC).
- FSM states and transitions:
  - IDLE: ready = 1. A non-0xA5 byte is accepted and discarded. An accepted 0xA5 clears done_o, error_o, index and checksum, then goes to LUT_LO.
  - LUT_LO: ready = 1. Accept byte into lut[7:0], XOR into checksum, go to LUT_HI.
  - LUT_HI: ready = 1. Accept byte into lut[15:8], XOR into checksum, go to CTRL.
  - CTRL: ready = 1. Accept byte and XOR into checksum.
    - Reserved bits nonzero: go to ERROR; no write occurs for this cell.
    - Otherwise: go to WRITE.
  - WRITE: exactly one cycle, ready = 0.
    - config_lut_o = assembled word; config_lut_we_o = 1 << index, both in this cycle only.
    - mux_sync_o[index] and mux_carry_o[index] update on the edge entering WRITE; visible during the pulse.
    - If index == N_CELLS-1, go to CHECK. Otherwise index++ and go to LUT_LO.
  - CHECK: ready = 1. Accept byte.
    - Equal to checksum: go to DONE.
    - Otherwise: go to ERROR.
  - DONE: one cycle. Set done_o, then go to IDLE.
  - ERROR: one cycle. Set error_o, then go to IDLE.
- Output timing:
  - busy_o = 1 in every state except IDLE.
  - config_lut_o keeps its last written value between pulses. we is zero outside WRITE.
  - done_o and error_o stay set until the next accepted SYNC byte or reset.
- Boundary conditions:
  - A 0xA5 byte inside the payload is ordinary data.
  - in_valid_i low stalls the FSM indefinitely; state is held.
  - Cells written before an error keep their new LUT and mux values. There is no rollback; error_o tells software to reload.
  - Reset mid-frame: immediate return to the reset values above. No partial pulse may appear after reset assertion.
  - At most one write-enable bit is ever high.
- Throughput: 3 accepted bytes + 1 WRITE cycle per cell at full valid.

Decomposition:
- Package fpga_cfg_pkg holds:
  - state enum cfg_state_t: IDLE, LUT_LO, LUT_HI, CTRL, WRITE, CHECK, DONE, ERROR.
  - SYNC_BYTE = 8'hA5.
  - CTRL_SYNC_BIT = 0, CTRL_CARRY_BIT = 1, CTRL_RSVD_MASK = 8'hFC.
- Sub-module fpga_cfg_checksum: 8-bit XOR accumulator with clear, enable, data in, value out; async active-low reset.

Test Plan:
1. N_CELLS=2, stream A5,34,12,01,CD,AB,02,43 -> we=01 with lut=0x1234, then we=10 with lut=0xABCD; mux_sync_o=01, mux_carry_o=10; done_o=1, error_o=0.
2. Same stream with CHK=0x44 -> both writes occur; error_o=1, done_o=0; mux outputs as in test 1.
3. Cell-0 CTRL=0x05 -> ERROR; no we pulse at all; error_o=1; mux outputs stay 0.
4. Leading bytes 00,FF,A5 then a valid frame -> 00 and FF are discarded; frame loads normally; done_o=1.
5. in_valid_i toggled randomly through test 1 -> identical outputs; in_ready_o=0 only in WRITE cycles.
6. reset_ni low right after the cell-0 WRITE -> all outputs 0 and in_ready_o=1 immediately; a fresh full frame then loads and sets done_o.
